// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the picoMIPS register-file port arbiter.
package regfile_arb_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] addr, input int nregs);
    return int'(addr) < nregs;
  endfunction

endpackage

// File: rtl/regfile_arb_resp.sv
// Per-port registered response: rvalid pulses one cycle after a grant,
// rdata captures the register file on reads and is forced to 0 on address errors.
module regfile_arb_resp
  import regfile_arb_pkg::*;
#(
  parameter int n = DATA_W
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         gnt_i,
  input  logic         we_i,
  input  logic         addr_err_i,
  input  logic [n-1:0] rf_rdata_i,
  output logic         rvalid_o,
  output logic [n-1:0] rdata_o,
  output logic         err_o
);

  logic         rvalid_q, rvalid_d;
  logic         err_q, err_d;
  logic [n-1:0] rdata_q, rdata_d;

  always_comb begin
    rvalid_d = gnt_i;
    err_d    = gnt_i & addr_err_i;
    rdata_d  = rdata_q;
    // Writes only mark completion, so rdata keeps the last read value.
    if (gnt_i) begin
      if (addr_err_i)  rdata_d = '0;
      else if (!we_i)  rdata_d = rf_rdata_i;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

endmodule

// File: rtl/regfile_port_arbiter.sv
// Arbitrates the shared register-file port between the core and the debug port,
// with debug aging and a halt mode that locks the core out.
module regfile_port_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int n        = DATA_W,  // must equal DATA_W, the req_t data width
  parameter int NREGS    = 14,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              nreset,
  // Handshake: a requester holds req/we/addr/wdata stable until gnt; the
  // transfer completes at the edge where gnt is high, and rvalid answers a cycle later.
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [n-1:0]      core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [n-1:0]      core_rdata,
  output logic              core_err,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [n-1:0]      dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [n-1:0]      dbg_rdata,
  output logic              dbg_err,
  input  logic              dbg_halt,
  output logic              halt_ack,
  output logic              rf_w,
  output logic [n-1:0]      rf_Wdata,
  output logic [ADDR_W-1:0] rf_Raddr1,
  output logic [ADDR_W-1:0] rf_Raddr2,
  input  logic [n-1:0]      rf_Rdata2
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_t     state_q, state_d;
  logic [3:0] wait_q, wait_d;
  req_t       sel;
  logic       any_gnt;
  logic       core_addr_err, dbg_addr_err;

  assign core_addr_err = !addr_ok(core_addr, NREGS);
  assign dbg_addr_err  = !addr_ok(dbg_addr, NREGS);

  always_comb begin
    core_gnt = 1'b0;
    dbg_gnt  = 1'b0;
    state_d  = dbg_halt ? HALTED : RUN;
    if (nreset) begin
      if (state_q == RUN) begin
        // Core wins contention until the debug port has aged to MAX_WAIT.
        if (core_req && !(dbg_req && wait_q == MAX_WAIT_C)) core_gnt = 1'b1;
        else if (dbg_req)                                   dbg_gnt  = 1'b1;
      end else begin
        dbg_gnt = dbg_req;
      end
    end
  end

  always_comb begin
    wait_d = wait_q;
    if (!dbg_req || dbg_gnt)     wait_d = 4'd0;
    else if (wait_q < MAX_WAIT_C) wait_d = wait_q + 4'd1;
  end

  always_comb begin
    sel = '0;
    if (core_gnt)     sel = '{we: core_we, addr: core_addr, wdata: core_wdata};
    else if (dbg_gnt) sel = '{we: dbg_we, addr: dbg_addr, wdata: dbg_wdata};
  end

  assign any_gnt   = core_gnt | dbg_gnt;
  assign rf_w      = any_gnt & sel.we & (sel.addr != '0) & addr_ok(sel.addr, NREGS);
  assign rf_Wdata  = sel.wdata;
  assign rf_Raddr1 = sel.addr;
  assign rf_Raddr2 = sel.addr;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= RUN;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign halt_ack = (state_q == HALTED);

  regfile_arb_resp #(.n(n)) u_core_resp (
    .clk        (clk),
    .nreset     (nreset),
    .gnt_i      (core_gnt),
    .we_i       (core_we),
    .addr_err_i (core_addr_err),
    .rf_rdata_i (rf_Rdata2),
    .rvalid_o   (core_rvalid),
    .rdata_o    (core_rdata),
    .err_o      (core_err)
  );

  regfile_arb_resp #(.n(n)) u_dbg_resp (
    .clk        (clk),
    .nreset     (nreset),
    .gnt_i      (dbg_gnt),
    .we_i       (dbg_we),
    .addr_err_i (dbg_addr_err),
    .rf_rdata_i (rf_Rdata2),
    .rvalid_o   (dbg_rvalid),
    .rdata_o    (dbg_rdata),
    .err_o      (dbg_err)
  );

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a behavioural register file,
// a reference register model and per-port expected-response queues.
module tb_regfile_port_arbiter;

  logic       clk = 1'b0;
  logic       nreset;
  logic       core_req, core_we, dbg_req, dbg_we, dbg_halt;
  logic [3:0] core_addr, dbg_addr;
  logic [7:0] core_wdata, dbg_wdata;
  logic       core_gnt, core_rvalid, core_err, dbg_gnt, dbg_rvalid, dbg_err;
  logic [7:0] core_rdata, dbg_rdata;
  logic       halt_ack, rf_w;
  logic [7:0] rf_Wdata, rf_Rdata2;
  logic [3:0] rf_Raddr1, rf_Raddr2;

  int checks = 0;
  int failures = 0;

  logic [8:0] core_q[$];
  logic [8:0] dbg_q[$];
  logic [7:0] ref_mem[14];
  logic [7:0] rf_mem[14];
  logic [7:0] last_rdata[2];

  // clock / reset block
  always #5 clk = ~clk;

  regfile_port_arbiter dut (
    .clk(clk), .nreset(nreset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata), .core_err(core_err),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
    .dbg_halt(dbg_halt), .halt_ack(halt_ack),
    .rf_w(rf_w), .rf_Wdata(rf_Wdata), .rf_Raddr1(rf_Raddr1), .rf_Raddr2(rf_Raddr2),
    .rf_Rdata2(rf_Rdata2)
  );

  // Behavioural register file: r0 and unimplemented addresses read as 0.
  always @(posedge clk) if (rf_w && rf_Raddr2 < 4'd14) rf_mem[rf_Raddr2] <= rf_Wdata;
  assign rf_Rdata2 = (rf_Raddr2 == 4'd0 || rf_Raddr2 >= 4'd14) ? 8'h00 : rf_mem[rf_Raddr2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_resp(input int port);
    logic [8:0] e;
    if (port == 0) begin
      if (core_q.size() > 0) begin
        e = core_q.pop_front();
        chk("core_rvalid", 32'(core_rvalid), 32'd1);
        chk("core_rdata", 32'(core_rdata), 32'(e[7:0]));
        chk("core_err", 32'(core_err), 32'(e[8]));
      end else chk("core_rvalid_idle", 32'(core_rvalid), 32'd0);
    end else begin
      if (dbg_q.size() > 0) begin
        e = dbg_q.pop_front();
        chk("dbg_rvalid", 32'(dbg_rvalid), 32'd1);
        chk("dbg_rdata", 32'(dbg_rdata), 32'(e[7:0]));
        chk("dbg_err", 32'(dbg_err), 32'(e[8]));
      end else chk("dbg_rvalid_idle", 32'(dbg_rvalid), 32'd0);
    end
  endtask

  task automatic expect_txn(input int port, input logic we, input logic [3:0] addr,
                            input logic [7:0] wd);
    logic       ok, ew;
    logic [8:0] e;
    ok = (addr < 4'd14);
    ew = we && addr != 4'd0 && ok;
    chk("rf_w", 32'(rf_w), 32'(ew));
    chk("rf_Raddr1", 32'(rf_Raddr1), 32'(addr));
    chk("rf_Raddr2", 32'(rf_Raddr2), 32'(addr));
    if (we) chk("rf_Wdata", 32'(rf_Wdata), 32'(wd));
    if (!ok)     e = {1'b1, 8'h00};
    else if (we) e = {1'b0, last_rdata[port]};
    else         e = {1'b0, ref_mem[addr]};
    last_rdata[port] = e[7:0];
    if (ew) ref_mem[addr] = wd;
    if (port == 0) core_q.push_back(e);
    else           dbg_q.push_back(e);
  endtask

  // driver: one cycle, inputs applied just after the rising edge, checks at the falling edge
  task automatic step(input logic c_req, c_we, input logic [3:0] c_addr, input logic [7:0] c_wd,
                      input logic d_req, d_we, input logic [3:0] d_addr, input logic [7:0] d_wd,
                      input logic halt, input logic exp_cg, exp_dg);
    core_req = c_req; core_we = c_we; core_addr = c_addr; core_wdata = c_wd;
    dbg_req = d_req; dbg_we = d_we; dbg_addr = d_addr; dbg_wdata = d_wd;
    dbg_halt = halt;
    @(negedge clk);
    check_resp(0);
    check_resp(1);
    chk("core_gnt", 32'(core_gnt), 32'(exp_cg));
    chk("dbg_gnt", 32'(dbg_gnt), 32'(exp_dg));
    if (exp_cg)      expect_txn(0, c_we, c_addr, c_wd);
    else if (exp_dg) expect_txn(1, d_we, d_addr, d_wd);
    else begin
      chk("rf_w_idle", 32'(rf_w), 32'd0);
      chk("rf_addr_idle", 32'(rf_Raddr2), 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic halt);
    step(0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00, halt, 0, 0);
  endtask

  initial begin
    logic [3:0] a;
    logic [7:0] d;
    for (int i = 0; i < 14; i++) begin ref_mem[i] = 8'h00; rf_mem[i] = 8'h00; end
    last_rdata[0] = 8'h00;
    last_rdata[1] = 8'h00;
    nreset = 1'b0;
    core_req = 1'b1; core_we = 1'b0; core_addr = 4'd3; core_wdata = 8'h00;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 4'd3; dbg_wdata = 8'h00; dbg_halt = 1'b0;
    #12;
    chk("rst_core_gnt", 32'(core_gnt), 32'd0);
    chk("rst_dbg_gnt", 32'(dbg_gnt), 32'd0);
    chk("rst_outputs", 32'({core_rvalid, core_err, core_rdata, dbg_rvalid, dbg_err, dbg_rdata, halt_ack}), 32'd0);
    core_req = 1'b0; dbg_req = 1'b0;
    @(negedge clk) nreset = 1'b1;
    @(posedge clk); #1;

    // core write r3 then read r3
    step(1, 1, 4'd3, 8'h5A, 0, 0, 4'd0, 8'h00, 0, 1, 0);
    step(1, 0, 4'd3, 8'h00, 0, 0, 4'd0, 8'h00, 0, 1, 0);
    idle(0);

    // contention and aging: debug wins every fifth cycle
    for (int i = 0; i < 10; i++)
      step(1, 0, 4'd3, 8'h00, 1, 0, 4'd3, 8'h00, 0, !(i == 4 || i == 9), (i == 4 || i == 9));
    idle(0);

    // halt: core locked out while debug writes r7
    idle(1);
    chk("halt_ack_set", 32'(halt_ack), 32'd1);
    step(1, 0, 4'd7, 8'h00, 1, 1, 4'd7, 8'hC3, 1, 0, 1);
    step(1, 0, 4'd7, 8'h00, 0, 0, 4'd0, 8'h00, 1, 0, 0);
    step(1, 0, 4'd7, 8'h00, 0, 0, 4'd0, 8'h00, 0, 0, 0);
    chk("halt_ack_clr", 32'(halt_ack), 32'd0);
    step(1, 0, 4'd7, 8'h00, 0, 0, 4'd0, 8'h00, 0, 1, 0);
    idle(0);

    // boundary addresses
    step(0, 0, 4'd0, 8'h00, 1, 1, 4'd0, 8'hFF, 0, 0, 1);
    step(0, 0, 4'd0, 8'h00, 1, 0, 4'd0, 8'h00, 0, 0, 1);
    step(1, 0, 4'd14, 8'h00, 0, 0, 4'd0, 8'h00, 0, 1, 0);
    step(1, 0, 4'd3, 8'h00, 0, 0, 4'd0, 8'h00, 0, 1, 0);
    step(1, 1, 4'd15, 8'h77, 0, 0, 4'd0, 8'h00, 0, 1, 0);
    idle(0);

    // random core writes read back through the debug port
    for (int i = 0; i < 4; i++) begin
      a = 4'($urandom_range(1, 13));
      d = 8'($urandom_range(0, 255));
      step(1, 1, a, d, 0, 0, 4'd0, 8'h00, 0, 1, 0);
      step(0, 0, 4'd0, 8'h00, 1, 0, a, 8'h00, 0, 0, 1);
    end
    idle(0);

    // async reset between a grant edge and its response cycle, while halted
    idle(1);
    step(0, 0, 4'd0, 8'h00, 1, 0, 4'd14, 8'h00, 1, 0, 1);
    nreset = 1'b0;
    #1;
    chk("mid_rst_rvalid", 32'(dbg_rvalid), 32'd0);
    chk("mid_rst_err", 32'(dbg_err), 32'd0);
    chk("mid_rst_halt_ack", 32'(halt_ack), 32'd0);
    chk("mid_rst_gnt", 32'(dbg_gnt), 32'd0);
    core_q.delete();
    dbg_q.delete();
    last_rdata[0] = 8'h00;
    last_rdata[1] = 8'h00;
    dbg_req = 1'b0; dbg_halt = 1'b0;
    @(negedge clk) nreset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_halt_ack", 32'(halt_ack), 32'd0);
    step(1, 0, 4'd7, 8'h00, 0, 0, 4'd0, 8'h00, 0, 1, 0);
    idle(0);

    chk("core_q_drained", 32'(core_q.size()), 32'd0);
    chk("dbg_q_drained", 32'(dbg_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_port_arbiter.md
Name: regfile_port_arbiter

Overview:
- Shares the picoMIPS 14-entry register file between two requesters: the core (primary) and a debug/host port (secondary).
- Grants one single-register read or write per cycle and drives the register-file port signals.
- Returns read data one cycle after grant.
- Provides a debug halt mode in which only the debug port has access.

Parameters:
- n, 8, data bus width; must match the register file.
- NREGS, 14, number of implemented registers; valid addresses are 0..NREGS-1.
- MAX_WAIT, 4, consecutive denied cycles after which a pending debug request takes priority over the core (range 1..15).

Ports:
- clk  in  1  clock, rising edge
- nreset  in  1  reset, asynchronous, active-low
- core_req  in  1  core request valid; held stable until core_gnt
- core_we  in  1  1 = write, 0 = read
- core_addr  in  4  register address
- core_wdata  in  n  write data
- core_gnt  out  1  combinational grant; the transfer completes at this clock edge
- core_rvalid  out  1  registered; read/err response valid, one cycle after grant
- core_rdata  out  n  registered read data
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1,1,4,n  same as the core_* inputs, for the debug port
- dbg_gnt, dbg_rvalid, dbg_rdata  out  1,1,n  same as the core_* outputs, for the debug port
- core_err, dbg_err  out  1  registered; valid with *_rvalid; address >= NREGS
- dbg_halt  in  1  debug requests exclusive access
- halt_ack  out  1  registered; high in HALTED
- rf_w  out  1  register-file write enable
- rf_Wdata  out  n  register-file write data
- rf_Raddr1  out  4  register-file read address 1
- rf_Raddr2  out  4  register-file read address 2; also the write destination
- rf_Rdata2  in  n  register-file read data 2 (combinational)

Behaviour:
- Reset (nreset low, async):
  - FSM = RUN; wait counter = 0.
  - All registered outputs are 0: *_rvalid, *_rdata, *_err, halt_ack.
  - Grants are 0 while reset is held.
- FSM has two states, RUN and HALTED:
  - RUN -> HALTED on the clock edge where dbg_halt = 1.
  - HALTED -> RUN on the clock edge where dbg_halt = 0.
  - halt_ack = (state == HALTED).
- Arbitration in RUN (evaluated every cycle):
  - Only core_req: grant core.
  - Only dbg_req: grant dbg.
  - Both requesting: grant core, unless wait counter == MAX_WAIT, in which case grant dbg.
- Arbitration in HALTED: only dbg can be granted; core_gnt = 0 and the core request stays pending. The counter is not used.
- Wait counter (4-bit):
  - Increments when dbg_req = 1 and dbg_gnt = 0, saturating at MAX_WAIT.
  - Clears on dbg_gnt, or when dbg_req = 0.
- At most one grant per cycle. The granted requester's address and data drive the register file:
  - rf_Raddr1 = rf_Raddr2 = addr.
  - rf_Wdata = wdata.
  - rf_w = we & gnt & (addr != 0) & (addr < NREGS).
- Writes to address 0 are suppressed silently (no error).
- Reads:
  - rdata <= rf_Rdata2 at the grant edge; rvalid goes high for exactly 1 cycle after the grant.
  - Address 0 returns 0 (register file guarantees this).
- Writes: rvalid is also pulsed for 1 cycle as a completion marker; rdata holds its previous value.
- Address >= NREGS (read or write):
  - The request is granted and consumed, with rf_w = 0.
  - rvalid = 1, err = 1, rdata = 0 in the next cycle.
- No grant in a cycle: rf_w = 0; rf address outputs = 0.
- Back-to-back grants to the same port in consecutive cycles are legal, giving continuous rvalid.
- Reset mid-operation: pending responses are lost and the FSM returns to RUN. Requesters must reissue.

Decomposition:
- Package regfile_arb_pkg:
  - typedef state_t {RUN, HALTED}
  - typedef req_t {we, addr[3:0], wdata}
  - localparam ADDR_W = 4
- Sub-module regfile_arb_resp: one per port, instantiated twice. Holds the registered rvalid/rdata/err response logic.

Test Plan:
- Core-only write/read: core writes 0x5A to r3; next cycle core reads r3 -> core_gnt is high in both request cycles, core_rvalid is high 1 cycle after the read grant, core_rdata = 0x5A, core_err = 0.
- Contention and aging (MAX_WAIT = 4): core_req and dbg_req held high continuously -> core granted for cycles 0-3, dbg granted in cycle 4, counter back to 0, core granted again from cycle 5.
- Halt: assert dbg_halt -> halt_ack = 1 the next cycle; core_req stays unserved (core_gnt = 0); dbg writes 0xC3 to r7; drop dbg_halt -> the pending core read of r7 is granted and returns 0xC3.
- Boundary addresses:
  - dbg writes 0xFF to r0 -> rf_w = 0; a later read of r0 returns 0x00 with no error.
  - core reads r14 -> rvalid = 1, err = 1, rdata = 0x00.
  - core writes r15 -> rf_w = 0, err = 1.
- Async reset mid-transfer: assert nreset low between a grant edge and its rvalid cycle -> rvalid and err are 0 immediately, halt_ack = 0, FSM is RUN after release.
